// File: rtl/key_matrix_scanner_pkg.sv
// key_matrix_scanner_pkg: shared widths, scan divider default and state/frame encodings for the key scanner.
package key_matrix_scanner_pkg;
  localparam int KEY_BITS = 4;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 4;
  localparam int KEY_SCAN_DIV = 200000;
  typedef enum logic [1:0] {
    KS_IDLE        = 2'd0,
    KS_PRESS_DEB   = 2'd1,
    KS_HELD        = 2'd2,
    KS_RELEASE_DEB = 2'd3
  } ks_state_e;
  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_e;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider emitting a 1-clk tick every SCAN_DIV cycles.
module scan_tick_gen
  import key_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV = KEY_SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(SCAN_DIV - 1);
  assign cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a 4x4 active-low key matrix, debounces whole frames and reports one key.
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = KEY_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ROW_BITS-1:0] row_in,
  output logic [COL_BITS-1:0] col_out,
  output logic [KEY_BITS-1:0] key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  logic tick, frame_end, single, none;
  logic [ROW_BITS-1:0] sync1_q, sync2_q;
  logic [1:0] col_q;
  logic [15:0] snap_q, frame;
  logic [4:0] n_pressed;
  logic [3:0] key_k, cnt_q, cnt_d, cnt_inc, cand_q, cand_d, code_q, code_d;
  logic held_q, held_d, valid_q, valid_d, rel_q, rel_d;
  frame_e kind;
  ks_state_e state_q, state_d;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );
  assign frame_end = tick && col_q == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      col_q   <= '0;
      snap_q  <= '1;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      if (tick) begin
        snap_q[{col_q, 2'b00} +: 4] <= sync2_q;
        col_q <= col_q + 2'd1;
      end
    end
  // Column 3 is classified straight from the synchroniser, the same value snapshotted at frame end.
  always_comb begin
    frame = {sync2_q, snap_q[11:0]};
    n_pressed = '0;
    key_k = '0;
    for (int i = 15; i >= 0; i--)
      if (!frame[i]) begin
        n_pressed = n_pressed + 5'd1;
        key_k = 4'(i);
      end
    kind = n_pressed == 5'd0 ? FR_NONE : n_pressed == 5'd1 ? FR_SINGLE : FR_MULTI;
  end
  assign single  = kind == FR_SINGLE;
  assign none    = kind == FR_NONE;
  assign cnt_inc = cnt_q + 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      rel_q   <= rel_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    rel_d   = 1'b0;
    if (frame_end)
      unique case (state_q)
        KS_IDLE:
          if (single) begin
            cand_d = key_k;
            cnt_d  = 4'd1;
            if (DEB == 4'd1) begin
              state_d = KS_HELD;
              code_d  = key_k;
              held_d  = 1'b1;
              valid_d = 1'b1;
            end else state_d = KS_PRESS_DEB;
          end
        KS_PRESS_DEB:
          if (single && key_k == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              state_d = KS_HELD;
              code_d  = cand_q;
              held_d  = 1'b1;
              valid_d = 1'b1;
            end
          end else begin
            state_d = KS_IDLE;
            cnt_d   = '0;
          end
        KS_HELD:
          if (!(single && key_k == code_q)) begin
            if (none && DEB == 4'd1) begin
              state_d = KS_IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = KS_RELEASE_DEB;
              cnt_d   = none ? 4'd1 : 4'd0;
            end
          end
        KS_RELEASE_DEB:
          if (none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              state_d = KS_IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
              rel_d   = 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = (single && key_k == code_q) ? KS_HELD : KS_RELEASE_DEB;
          end
      endcase
  end
  assign col_out     = ~(4'b0001 << col_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = rel_q;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: frame-aligned stimulus with a matrix model; expected per-frame outputs queued and checked.
module tb_key_matrix_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] row_in, col_out, key_code;
  logic key_valid, key_held, key_release;
  logic [15:0] pressed = '0;
  int tests = 0;
  int failed = 0;
  typedef struct {
    logic v;
    logic r;
    logic h;
    logic [3:0] c;
  } exp_t;
  exp_t exp_q[$];

  key_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Pressed key at {col,row} pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
  end

  task automatic wait_frame_end(input string name);
    logic [3:0] prev;
    int stray;
    bit found;
    prev = col_out;
    stray = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_out == 4'b1110) found = 1;
      else stray += int'(key_valid) + int'(key_release);
      prev = col_out;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL %s frame_timeout: got no frame end in 40 clk, want one within 16", name);
    end
    tests++;
    if (stray != 0) begin
      failed++;
      $display("FAIL %s stray_pulse: got %0d mid-frame pulses, want 0", name, stray);
    end
  endtask

  task automatic run_frame(input string name, input logic [15:0] pat, input logic v, input logic r,
                           input logic h, input logic [3:0] c);
    exp_t e;
    pressed = pat;
    exp_q.push_back('{v: v, r: r, h: h, c: c});
    wait_frame_end(name);
    e = exp_q.pop_front();
    tests += 4;
    if (key_valid !== e.v) begin
      failed++;
      $display("FAIL %s key_valid: got %b want %b", name, key_valid, e.v);
    end
    if (key_release !== e.r) begin
      failed++;
      $display("FAIL %s key_release: got %b want %b", name, key_release, e.r);
    end
    if (key_held !== e.h) begin
      failed++;
      $display("FAIL %s key_held: got %b want %b", name, key_held, e.h);
    end
    if (key_code !== e.c) begin
      failed++;
      $display("FAIL %s key_code: got %h want %h", name, key_code, e.c);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || key_release !== 1'b0) begin
      failed++;
      $display("FAIL %s outputs: got col=%b code=%h v=%b h=%b r=%b want col=1110 code=0 v=0 h=0 r=0",
               name, col_out, key_code, key_valid, key_held, key_release);
    end
  endtask

  task automatic test_reset;
    logic [3:0] e;
    rst_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((k / 4) % 4));
      tests++;
      if (col_out !== e) begin
        failed++;
        $display("FAIL rotate[%0d] col_out: got %b want %b", k, col_out, e);
      end
    end
  endtask

  task automatic test_press;
    run_frame("press1", 16'h0040, 0, 0, 0, 4'h0);
    run_frame("press2", 16'h0040, 0, 0, 0, 4'h0);
    run_frame("press3", 16'h0040, 1, 0, 1, 4'h6);
    run_frame("press4", 16'h0040, 0, 0, 1, 4'h6);
  endtask

  task automatic test_ghost_held;
    for (int i = 0; i < 4; i++) run_frame("ghost_held", 16'h0041, 0, 0, 1, 4'h6);
    run_frame("ghost_held_back", 16'h0040, 0, 0, 1, 4'h6);
  endtask

  task automatic test_release;
    run_frame("release1", 16'h0000, 0, 0, 1, 4'h6);
    run_frame("release2", 16'h0000, 0, 0, 1, 4'h6);
    run_frame("release3", 16'h0000, 0, 1, 0, 4'h6);
    run_frame("release4", 16'h0000, 0, 0, 0, 4'h6);
  endtask

  task automatic test_bounce;
    run_frame("bounce1", 16'h0040, 0, 0, 0, 4'h6);
    run_frame("bounce2", 16'h0040, 0, 0, 0, 4'h6);
    run_frame("bounce3", 16'h0000, 0, 0, 0, 4'h6);
    run_frame("bounce4", 16'h0040, 0, 0, 0, 4'h6);
    run_frame("bounce5", 16'h0040, 0, 0, 0, 4'h6);
    run_frame("bounce6", 16'h0040, 1, 0, 1, 4'h6);
    test_release();
  endtask

  task automatic test_ghost;
    for (int i = 0; i < 5; i++) run_frame("ghost_idle", 16'h2001, 0, 0, 0, 4'h6);
    run_frame("ghost_clear", 16'h0000, 0, 0, 0, 4'h6);
  endtask

  task automatic test_back_to_back;
    run_frame("b2b1", 16'h8000, 0, 0, 0, 4'h6);
    run_frame("b2b2", 16'h8000, 0, 0, 0, 4'h6);
    run_frame("b2b3", 16'h8000, 1, 0, 1, 4'hF);
    run_frame("b2b_rel1", 16'h0000, 0, 0, 1, 4'hF);
    run_frame("b2b_rel2", 16'h0000, 0, 0, 1, 4'hF);
    run_frame("b2b_rel3", 16'h0000, 0, 1, 0, 4'hF);
  endtask

  task automatic test_reset_mid;
    run_frame("mid1", 16'h0040, 0, 0, 0, 4'hF);
    run_frame("mid2", 16'h0040, 0, 0, 0, 4'hF);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame("after_rst1", 16'h0040, 0, 0, 0, 4'h0);
    run_frame("after_rst2", 16'h0040, 0, 0, 0, 4'h0);
    run_frame("after_rst3", 16'h0040, 1, 0, 1, 4'h6);
  endtask

  initial begin
    test_reset();
    test_press();
    test_ghost_held();
    test_release();
    test_bounce();
    test_ghost();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
